// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Optional build macro used by the controller: SCAN_BLANK_EN.
package disp_pkg;

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex values 0..F.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Next enabled digit strictly after cur, wrapping; holds when the mask is empty.
    function automatic logic [2:0] next_enabled(input logic [2:0] cur, input logic [7:0] en);
        logic [2:0] res;
        logic [2:0] cand;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = cur + 3'(k);
            if (!found && en[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Display-side bundle: digit data and masks in, pin drive and scan index out.
interface disp_scan_if;
    logic [31:0] digits;
    logic [7:0]  dp_in;
    logic [7:0]  dig_en;
    logic [7:0]  blink_en;
    logic        blink_phase;
    logic [7:0]  an_out;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [2:0]  scan_idx;

    modport master (
        output digits, dp_in, dig_en, blink_en, blink_phase,
        input  an_out, seg_out, dp_out, scan_idx
    );

    modport slave (
        input  digits, dp_in, dig_en, blink_en, blink_phase,
        output an_out, seg_out, dp_out, scan_idx
    );
endinterface

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_hex_decode
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit multiplexed display scanner with registered pin outputs.
// Define SCAN_BLANK_EN to insert BLANK_CYC dead cycles between digits.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int DIV       = 100000,
    parameter int BLANK_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    disp_scan_if.slave  bus
);
    localparam int CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX);

    scan_state_t       state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]        idx, idx_nxt;
    logic              drive_last;
    logic [3:0]        nibble;
    logic [6:0]        seg_dec;
    logic              an_on;
    logic [7:0]        an_q;
    logic [6:0]        seg_q;
    logic              dp_q;

    assign drive_last = (cnt == CNT_W'(DIV - 1));

`ifdef SCAN_BLANK_EN
    logic blank_last;
    assign blank_last = (cnt == CNT_W'(BLANK_CYC - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DRIVE;
            cnt   <= '0;
            idx   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // The counter only ever reaches the terminal value of the current state before clearing.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        idx_nxt   = idx;
        case (state)
            DRIVE: begin
                if (drive_last) begin
                    cnt_nxt = '0;
`ifdef SCAN_BLANK_EN
                    state_nxt = BLANK;
`else
                    idx_nxt = next_enabled(idx, bus.dig_en);
`endif
                end
            end
            BLANK: begin
`ifdef SCAN_BLANK_EN
                if (blank_last) begin
                    cnt_nxt   = '0;
                    idx_nxt   = next_enabled(idx, bus.dig_en);
                    state_nxt = DRIVE;
                end
`else
                cnt_nxt   = '0;
                state_nxt = DRIVE;
`endif
            end
        endcase
    end

    assign nibble = bus.digits[{idx, 2'b00} +: 4];

    seg_hex_decode u_dec (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    assign an_on = (state == DRIVE) && bus.dig_en[idx] &&
                   !(bus.blink_en[idx] && bus.blink_phase);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else if (an_on) begin
            an_q  <= ~(8'b1 << idx);
            seg_q <= seg_dec;
            dp_q  <= ~bus.dp_in[idx];
        end else begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end
    end

    assign bus.an_out   = an_q;
    assign bus.seg_out  = seg_q;
    assign bus.dp_out   = dp_q;
    assign bus.scan_idx = idx;

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It owns the refresh counter and steps a 3-bit digit index across the digits enabled in a mask. It drives active-low anodes, segments and decimal point from a packed nibble bus, and sits between the clock/alarm datapath and the board display pins.

## Interface
- `DIV`, 100000, clk cycles each digit is driven (≥2)
- `BLANK_CYC`, 8, clk cycles of all-off dead time between digits (≥1; used only with `SCAN_BLANK_EN`)
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `digits`  in  32  nibble per digit; digit k = `digits[4k+3:4k]`, hex value
- `dp_in`  in  8  decimal point request per digit, active-high
- `dig_en`  in  8  digit enable mask; disabled digits are skipped
- `blink_en`  in  8  digits subject to blinking
- `blink_phase`  in  1  1 = blinking digits are dark
- `an_out`  out  8  anodes, active-low, at most one low
- `seg_out`  out  7  segments {g,f,e,d,c,b,a}, active-low
- `dp_out`  out  1  decimal point, active-low
- `scan_idx`  out  3  digit currently selected

## Operation
- States: `DRIVE`, `BLANK`.
- Reset values: state = `DRIVE`, `scan_idx` = 0, counter = 0, `an_out` = 8'hFF, `seg_out` = 7'h7F, `dp_out` = 1.
- `DRIVE`: the counter increments each cycle. At `DIV-1` the counter clears, and the block goes to `BLANK` (macro on) or advances the index (macro off).
- `BLANK`: all outputs are off. At `BLANK_CYC-1` the counter clears, the index advances, and the block returns to `DRIVE`.
- Advance: the new index is the next enabled digit after the current one in ascending order, wrapping 7→0.
  - Only one enabled digit: the index stays on it.
  - `dig_en` = 0: the index holds.
- Output gating:
  - `an_out[scan_idx]` is low only in `DRIVE` when `dig_en[scan_idx]`=1 and not (`blink_en[scan_idx]` & `blink_phase`). Otherwise `an_out` = 8'hFF.
  - `seg_out` follows hex decode of the selected nibble (0–F) when the anode is on. Otherwise it is 7'h7F.
  - `dp_out` = ~`dp_in[scan_idx]` when the anode is on. Otherwise it is 1.
- Mask change while driving a digit that becomes disabled: anodes go off on the next cycle. The slot still runs to completion, then the index advances normally.
- Width: counter width = clog2(max(`DIV`,`BLANK_CYC`)). The counter never exceeds its terminal value.

## Timing
- All outputs are registered.
- Output latency is one cycle from any change in `scan_idx`, state, or inputs.
- Slot period: `DIV`+`BLANK_CYC` cycles with the macro, `DIV` without.
- First anode assertion after reset release is on cycle 1, on digit 0 if enabled. If digit 0 is disabled, all outputs are off until the first advance.
- `blink_phase` and `dig_en` are sampled every cycle and need no handshake.
- Reset assertion mid-slot forces outputs to their reset values immediately (async) and restarts at index 0.

## Configuration
- `SCAN_BLANK_EN` defined: the `BLANK` state exists and inserts `BLANK_CYC` dead cycles per digit, which suppresses ghosting.
- `SCAN_BLANK_EN` undefined: the state machine reduces to `DRIVE` only and `BLANK_CYC` is ignored. The anode switches directly between adjacent digits.

## Structure
- Package `disp_pkg` holds:
  - state enum {`DRIVE`, `BLANK`};
  - `SEG_OFF` = 7'h7F;
  - `AN_OFF` = 8'hFF;
  - the 16-entry hex-to-segment constant table.
- Sub-module `seg_hex_decode`: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.

## Test plan
Bench uses `DIV`=4, `BLANK_CYC`=2.
- Reset then release with `dig_en`=8'hF0 and `digits`=32'h1234_0000 → index sequence 4,5,6,7,4. `an_out` cycles EF, DF, BF, 7F. Digit 4 shows `seg_out`=7'h19 (value 4), and each slot is 6 cycles (macro on).
- `dig_en`=8'h00 → `an_out` stays 8'hFF and `scan_idx` holds for 50 cycles.
- `dig_en`=8'h20 → index is fixed at 5 and `an_out`=DF for 4 of every 6 cycles, 8'hFF during blank.
- `blink_en`=8'h80 and `blink_phase`=1 → the digit-7 slot shows `an_out`=8'hFF and `seg_out`=7'h7F. Other digits are unaffected, and with `blink_phase`=0 the slot shows 7F.
- `dp_in`=8'h40 → `dp_out`=0 only while `an_out`=BF.
- Reset asserted on the 2nd cycle of the digit-6 slot → same cycle `an_out`=8'hFF. After release the scan restarts from index 0. Rebuild without `SCAN_BLANK_EN` → slot is 4 cycles with no FF gaps between enabled digits.
